lane_swap_ram: RTL and testbench

LANE_SWAP_RAM -- requirements
Module: lane_swap_ram

---
 rtl/lane_swap_ram.sv | 186 ++++++++++++++++++
 tb/tb_lane_swap_ram.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/lane_swap_ram.sv
// lane_swap_ram
// Single-clock word RAM split into LANES equal lanes with per-lane write
// enables. Writes into the upper "swap region" (address >= SWAP_BASE) rotate
// the source lanes by ROT before storing; reads return the stored word as-is.
// After reset an INIT sweep zeroes every entry (DEPTH cycles) before the
// array accepts requests.
//
// Ports
//   clk          sole clock, rising edge
//   rst          synchronous active-high reset
//   in_wr        write request
//   in_wr_addr   write address
//   in_data      write data
//   in_mask      per-lane write enable, indexed by source lane of in_data
//   in_rd        read request
//   in_rd_addr   read address
//   out_data     registered read data, holds when out_valid is low
//   out_valid    one-cycle pulse, out_data updated this cycle
//   ready        high while the array is initialised and accepting requests
//   err_busy     one-cycle pulse, a request was dropped during INIT
module lane_swap_ram #(
  parameter int WIDTH     = 256,
  parameter int PSIZE     = 5,
  parameter int LANES     = 2,
  parameter int ROT       = 1,
  parameter int SWAP_BASE = (2**PSIZE) / 2,
  parameter int RD_LAT    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_wr,
  input  logic [PSIZE-1:0] in_wr_addr,
  input  logic [WIDTH-1:0] in_data,
  input  logic [LANES-1:0] in_mask,
  input  logic             in_rd,
  input  logic [PSIZE-1:0] in_rd_addr,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             ready,
  output logic             err_busy
);

  localparam int DEPTH = 2**PSIZE;
  localparam int LW    = WIDTH / LANES;
  localparam int PW1   = PSIZE + 1;

  localparam logic [0:0] ST_INIT  = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  // One extra bit so a SWAP_BASE of DEPTH (no swap region) still compares correctly.
  localparam logic [PSIZE:0]   SWAP_BASE_W = PW1'(SWAP_BASE);
  localparam logic [PSIZE-1:0] LAST_PTR    = PSIZE'(DEPTH - 1);
  localparam bit               TWO_STAGE   = (RD_LAT == 2);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [0:0]       state_q, state_d;
  logic [PSIZE-1:0] ptr_q, ptr_d;
  logic             ready_q;
  logic             err_busy_q;
  logic             s1_valid_q;
  logic [WIDTH-1:0] s1_data_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;

  logic             in_ready_s;
  logic             wr_acc_s;
  logic             rd_acc_s;
  logic             busy_s;
  logic             swap_s;
  logic [PSIZE-1:0] wr_addr_s;
  logic [LANES-1:0] lane_we_s;
  logic [WIDTH-1:0] lane_wd_s;
  logic [WIDTH-1:0] rd_word_s;
  logic             pipe_valid_s;
  logic [WIDTH-1:0] pipe_data_s;

  // Source lane feeding stored lane d; the swap region undoes the +ROT shift.
  function automatic int src_lane(input int d, input logic swap);
    if (swap) begin
      return (d + LANES - ROT) % LANES;
    end else begin
      return d;
    end
  endfunction

  // Request acceptance: only READY accepts; INIT flags dropped requests.
  always_comb begin
    in_ready_s = (state_q == ST_READY);
    wr_acc_s   = in_wr & in_ready_s;
    rd_acc_s   = in_rd & in_ready_s;
    busy_s     = (state_q == ST_INIT) & (in_wr | in_rd);
  end

  // INIT sweep pointer and state transition.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_INIT: begin
        ptr_d = ptr_q + PSIZE'(1);
        if (ptr_q == LAST_PTR) begin
          state_d = ST_READY;
        end else begin
          state_d = ST_INIT;
        end
      end
      ST_READY: begin
        state_d = ST_READY;
        ptr_d   = ptr_q;
      end
      default: begin
        state_d = ST_INIT;
        ptr_d   = {PSIZE{1'b0}};
      end
    endcase
  end

  // Per-lane write enables and data, lane-rotated in the swap region; INIT zeroes whole words.
  always_comb begin
    swap_s    = ({1'b0, in_wr_addr} >= SWAP_BASE_W);
    lane_we_s = {LANES{1'b0}};
    lane_wd_s = {WIDTH{1'b0}};
    if (state_q == ST_INIT) begin
      wr_addr_s = ptr_q;
      lane_we_s = {LANES{1'b1}};
    end else begin
      wr_addr_s = in_wr_addr;
      for (int d = 0; d < LANES; d++) begin
        lane_we_s[d]             = wr_acc_s & in_mask[src_lane(d, swap_s)];
        lane_wd_s[d*LW +: LW]    = in_data[src_lane(d, swap_s)*LW +: LW];
      end
    end
  end

  // Read-first array lookup and the latency-select mux for the output stage.
  always_comb begin
    rd_word_s    = mem_q[in_rd_addr];
    pipe_valid_s = TWO_STAGE ? s1_valid_q : rd_acc_s;
    pipe_data_s  = TWO_STAGE ? s1_data_q  : rd_word_s;
  end

  // Storage array; not reset, the INIT sweep clears it instead.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int d = 0; d < LANES; d++) begin
        if (lane_we_s[d]) begin
          mem_q[wr_addr_s][d*LW +: LW] <= lane_wd_s[d*LW +: LW];
        end
      end
    end
  end

  // Control state, status flags and read pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_INIT;
      ptr_q       <= {PSIZE{1'b0}};
      ready_q     <= 1'b0;
      err_busy_q  <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_data_q   <= {WIDTH{1'b0}};
      out_valid_q <= 1'b0;
      out_data_q  <= {WIDTH{1'b0}};
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      ready_q     <= (state_d == ST_READY);
      err_busy_q  <= busy_s;
      s1_valid_q  <= rd_acc_s;
      if (rd_acc_s) begin
        s1_data_q <= rd_word_s;
      end
      out_valid_q <= pipe_valid_s;
      if (pipe_valid_s) begin
        out_data_q <= pipe_data_s;
      end
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign ready     = ready_q;
  assign err_busy  = err_busy_q;

endmodule

// File: tb/tb_lane_swap_ram.sv
// tb_lane_swap_ram
// Drives two lane_swap_ram instances (RD_LAT=1 and RD_LAT=2) with the same
// stimulus and compares every cycle against a behavioural model built from
// the lane-rotation and timing rules, plus directed scenarios with constant
// expectations.
module tb_lane_swap_ram;

  localparam int WIDTH = 256;
  localparam int PSIZE = 5;
  localparam int LANES = 2;
  localparam int ROT   = 1;
  localparam int DEPTH = 32;
  localparam int SWAP_BASE = 16;
  localparam int LW    = WIDTH / LANES;

  localparam logic [LW-1:0] A_C = {4{32'hA5A5_0001}};
  localparam logic [LW-1:0] B_C = {4{32'hB6B6_0002}};
  localparam logic [LW-1:0] C_C = {4{32'hC7C7_0003}};
  localparam logic [LW-1:0] D_C = {4{32'hD8D8_0004}};

  logic             clk = 1'b0;
  logic             rst;
  logic             in_wr;
  logic [PSIZE-1:0] in_wr_addr;
  logic [WIDTH-1:0] in_data;
  logic [LANES-1:0] in_mask;
  logic             in_rd;
  logic [PSIZE-1:0] in_rd_addr;
  logic [WIDTH-1:0] out_data1, out_data2;
  logic             out_valid1, out_valid2;
  logic             ready1, ready2;
  logic             err_busy1, err_busy2;

  int n_checks = 0;
  int n_fail   = 0;

  // behavioural model state
  logic [WIDTH-1:0] mem_m [DEPTH];
  bit               ready_m, err_m, v1_m, v2_m, s1v_m;
  logic [WIDTH-1:0] d1_m, d2_m, s1d_m;
  int               remaining_m;
  bit               chk_en = 1'b0;

  always #5 clk = ~clk;

  lane_swap_ram #(.WIDTH(WIDTH), .PSIZE(PSIZE), .LANES(LANES), .ROT(ROT),
                  .SWAP_BASE(SWAP_BASE), .RD_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_wr(in_wr), .in_wr_addr(in_wr_addr),
    .in_data(in_data), .in_mask(in_mask), .in_rd(in_rd), .in_rd_addr(in_rd_addr),
    .out_data(out_data1), .out_valid(out_valid1), .ready(ready1), .err_busy(err_busy1)
  );

  lane_swap_ram #(.WIDTH(WIDTH), .PSIZE(PSIZE), .LANES(LANES), .ROT(ROT),
                  .SWAP_BASE(SWAP_BASE), .RD_LAT(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_wr(in_wr), .in_wr_addr(in_wr_addr),
    .in_data(in_data), .in_mask(in_mask), .in_rd(in_rd), .in_rd_addr(in_rd_addr),
    .out_data(out_data2), .out_valid(out_valid2), .ready(ready2), .err_busy(err_busy2)
  );

  task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock using the current inputs.
  task automatic model_update();
    logic [WIDTH-1:0] word;
    int dst;
    if (rst) begin
      ready_m = 1'b0; err_m = 1'b0; remaining_m = DEPTH;
      v1_m = 1'b0; d1_m = '0; v2_m = 1'b0; d2_m = '0; s1v_m = 1'b0; s1d_m = '0;
      chk_en = 1'b1;
    end else if (!ready_m) begin
      err_m = in_wr | in_rd;
      mem_m[DEPTH - remaining_m] = '0;
      remaining_m--;
      if (remaining_m == 0) ready_m = 1'b1;
      v1_m = 1'b0;
      v2_m = s1v_m;
      if (s1v_m) d2_m = s1d_m;
      s1v_m = 1'b0;
    end else begin
      err_m = 1'b0;
      word = mem_m[in_rd_addr];
      if (in_wr) begin
        for (int i = 0; i < LANES; i++) begin
          if (in_mask[i]) begin
            dst = (int'(in_wr_addr) >= SWAP_BASE) ? (i + ROT) % LANES : i;
            mem_m[in_wr_addr][dst*LW +: LW] = in_data[i*LW +: LW];
          end
        end
      end
      v1_m = in_rd;
      if (in_rd) d1_m = word;
      v2_m = s1v_m;
      if (s1v_m) d2_m = s1d_m;
      s1v_m = in_rd;
      if (in_rd) s1d_m = word;
    end
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
    if (chk_en) begin
      check("ready1",  {255'd0, ready1},     {255'd0, ready_m});
      check("ready2",  {255'd0, ready2},     {255'd0, ready_m});
      check("err1",    {255'd0, err_busy1},  {255'd0, err_m});
      check("err2",    {255'd0, err_busy2},  {255'd0, err_m});
      check("valid1",  {255'd0, out_valid1}, {255'd0, v1_m});
      check("valid2",  {255'd0, out_valid2}, {255'd0, v2_m});
      check("data1",   out_data1, d1_m);
      check("data2",   out_data2, d2_m);
    end
  endtask

  task automatic idle_inputs();
    in_wr = 1'b0; in_rd = 1'b0; in_mask = '0;
  endtask

  task automatic do_write(input logic [PSIZE-1:0] addr, input logic [WIDTH-1:0] data,
                          input logic [LANES-1:0] mask);
    in_wr = 1'b1; in_wr_addr = addr; in_data = data; in_mask = mask;
    step();
    idle_inputs();
  endtask

  // Read with constant expectation for both latencies.
  task automatic do_read(input string tag, input logic [PSIZE-1:0] addr, input logic [WIDTH-1:0] exp);
    in_rd = 1'b1; in_rd_addr = addr;
    step();
    idle_inputs();
    check({tag, "_v1"}, {255'd0, out_valid1}, {255'd0, 1'b1});
    check({tag, "_d1"}, out_data1, exp);
    step();
    check({tag, "_v2"}, {255'd0, out_valid2}, {255'd0, 1'b1});
    check({tag, "_d2"}, out_data2, exp);
  endtask

  task automatic wait_ready(input string tag, input int start);
    int cnt;
    cnt = start;
    while (!ready1 && cnt < 100) begin
      step();
      cnt++;
    end
    check(tag, WIDTH'(cnt), WIDTH'(32));
  endtask

  initial begin
    rst = 1'b1; in_wr_addr = '0; in_rd_addr = '0; in_data = '0;
    idle_inputs();
    step();
    step();
    check("rst_ready", {255'd0, ready1}, 256'd0);

    // Release reset, drop a write/read during INIT
    rst = 1'b0;
    in_wr = 1'b1; in_wr_addr = 5'd3; in_data = {A_C, B_C}; in_mask = 2'b11;
    in_rd = 1'b1; in_rd_addr = 5'd3;
    step();
    idle_inputs();
    check("init_err", {255'd0, err_busy1}, {255'd0, 1'b1});
    check("init_nov", {255'd0, out_valid1}, 256'd0);
    wait_ready("ready_lat", 1);

    do_read("rd7", 5'd7, '0);
    do_read("rd3_init", 5'd3, '0);

    do_write(5'd3, {A_C, B_C}, 2'b11);
    do_read("rd3", 5'd3, {A_C, B_C});
    do_write(5'd20, {A_C, B_C}, 2'b11);
    do_read("rd20", 5'd20, {B_C, A_C});
    do_write(5'd20, {C_C, D_C}, 2'b01);
    do_read("rd20m", 5'd20, {D_C, A_C});
    do_write(5'd20, {C_C, C_C}, 2'b00);
    do_read("rd20z", 5'd20, {D_C, A_C});

    do_write(5'd5, {A_C, B_C}, 2'b11);
    in_wr = 1'b1; in_wr_addr = 5'd5; in_data = {C_C, D_C}; in_mask = 2'b11;
    in_rd = 1'b1; in_rd_addr = 5'd5;
    step();
    idle_inputs();
    check("rf_old", out_data1, {A_C, B_C});
    step();
    do_read("rf_new", 5'd5, {C_C, D_C});

    // Reset 10 cycles into INIT, then with a read in flight
    rst = 1'b1; step(); rst = 1'b0;
    repeat (10) step();
    rst = 1'b1; step(); rst = 1'b0;
    wait_ready("restart_lat", 0);
    do_write(5'd9, {C_C, A_C}, 2'b11);
    in_rd = 1'b1; in_rd_addr = 5'd9;
    step();
    idle_inputs();
    rst = 1'b1;
    step();
    check("flush_v2", {255'd0, out_valid2}, 256'd0);
    check("flush_d2", out_data2, '0);
    rst = 1'b0;
    step();
    check("stale_v2", {255'd0, out_valid2}, 256'd0);
    wait_ready("rst_rd_lat", 1);
    do_read("rd9_clr", 5'd9, '0);

    // Randomised traffic against the model
    for (int n = 0; n < 400; n++) begin
      rst        = ($urandom_range(0, 199) == 0);
      in_wr      = $urandom_range(0, 1);
      in_rd      = $urandom_range(0, 1);
      in_wr_addr = PSIZE'($urandom_range(0, DEPTH - 1));
      in_rd_addr = ($urandom_range(0, 3) == 0) ? in_wr_addr : PSIZE'($urandom_range(0, DEPTH - 1));
      in_mask    = LANES'($urandom_range(0, 3));
      for (int w = 0; w < WIDTH / 32; w++) in_data[w*32 +: 32] = $urandom;
      step();
    end
    rst = 1'b0;
    idle_inputs();
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
